// File: rtl/divider_arbiter_pkg.sv
// div_arb_pkg: FSM states, word selects and flat-bus helpers for divider_arbiter
package div_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;
  typedef enum logic [2:0] {
    IDLE, SEND_A_HI, SEND_A_LO, SEND_B_HI, SEND_B_LO, WAIT_Z_HI, WAIT_Z_LO, RESP
  } state_t;
  function automatic logic [31:0] slice32(input logic [32*MAX_REQ-1:0] bus, input int idx);
    return bus[32*idx +: 32];
  endfunction
  function automatic logic [15:0] word(input logic [31:0] x, input logic sel);
    return sel ? x[31:16] : x[15:0];
  endfunction
endpackage

// File: rtl/divider_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker searching from ptr+1
module rr_pick
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDW-1:0]     index,
  output logic               any
);
  logic [IDW-1:0] idx;
  always_comb begin
    onehot = '0;
    index = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        index = idx;
        onehot[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one word-serial float divider
module divider_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [31:0]          rsp_z,
  output logic [15:0]          div_a,
  output logic                 div_a_stb,
  input  logic                 div_a_ack,
  output logic [15:0]          div_b,
  output logic                 div_b_stb,
  input  logic                 div_b_ack,
  input  logic [15:0]          div_z,
  input  logic                 div_z_stb,
  output logic                 div_z_ack,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [15:0]          done_count
);
  state_t state, next;
  logic [IDW-1:0] ptr, pick_index;
  logic [NUM_REQ-1:0] pick_onehot;
  logic pick_any, rsp_fire;
  logic [31:0] op_a, op_b, res;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .onehot(pick_onehot),
    .index(pick_index),
    .any(pick_any)
  );
  assign busy = state != IDLE;
  assign req_ready = (state == IDLE) ? pick_onehot : '0;
  assign div_a_stb = state inside {SEND_A_HI, SEND_A_LO};
  assign div_b_stb = state inside {SEND_B_HI, SEND_B_LO};
  assign div_z_ack = state inside {WAIT_Z_HI, WAIT_Z_LO};
  assign div_a = div_a_stb ? word(op_a, state == SEND_A_HI ? HI : LO) : '0;
  assign div_b = div_b_stb ? word(op_b, state == SEND_B_HI ? HI : LO) : '0;
  assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << grant_id : '0;
  assign rsp_z = res;
  assign rsp_fire = state == RESP && rsp_ready[grant_id];
  always_ff @(posedge clk)
    state <= !rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = pick_any ? SEND_A_HI : IDLE;
      SEND_A_HI: next = div_a_ack ? SEND_A_LO : SEND_A_HI;
      SEND_A_LO: next = div_a_ack ? SEND_B_HI : SEND_A_LO;
      SEND_B_HI: next = div_b_ack ? SEND_B_LO : SEND_B_HI;
      SEND_B_LO: next = div_b_ack ? WAIT_Z_HI : SEND_B_LO;
      WAIT_Z_HI: next = div_z_stb ? WAIT_Z_LO : WAIT_Z_HI;
      WAIT_Z_LO: next = div_z_stb ? RESP : WAIT_Z_LO;
      RESP:      next = rsp_fire ? IDLE : RESP;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= IDW'(NUM_REQ - 1);
      grant_id <= '0;
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      done_count <= '0;
    end else begin
      if (state == IDLE && pick_any) begin
        op_a <= slice32((32*MAX_REQ)'(req_a), int'(pick_index));
        op_b <= slice32((32*MAX_REQ)'(req_b), int'(pick_index));
        grant_id <= pick_index;
      end
      if (state == WAIT_Z_HI && div_z_stb) res[31:16] <= div_z;
      if (state == WAIT_Z_LO && div_z_stb) res[15:0] <= div_z;
      if (rsp_fire) begin
        ptr <= grant_id;
        done_count <= done_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed self-checking bench with a word-serial divider model
module tb_divider_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0] rsp_z;
  logic [15:0] div_a, div_b, div_z, done_count;
  logic div_a_stb, div_a_ack, div_b_stb, div_b_ack, div_z_stb, div_z_ack, busy;
  logic [1:0] grant_id;
  int errors = 0;
  int checks = 0;
  int hold = 0;
  logic stray = 1'b0;
  logic [15:0] words[$];
  int ph, cnt, hc;
  logic pend;
  logic [15:0] cw;
  logic [15:0] mw[4];
  logic [31:0] mz;
  divider_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
    .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
    .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
    .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
    .busy(busy), .grant_id(grant_id), .done_count(done_count)
  );
  function automatic logic [31:0] qmodel(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40C00000_40000000: return 32'h40400000;
      64'h3F800000_00000000: return 32'h7F800000;
      64'h00000000_00000000: return 32'hFFC00000;
      64'h41200000_40A00000: return 32'h40000000;
      default: return a ^ b;
    endcase
  endfunction
  initial begin
    ph = 0;
    cnt = 0;
    hc = 0;
    pend = 1'b0;
    cw = '0;
    mz = '0;
    div_a_ack = 1'b0;
    div_b_ack = 1'b0;
    div_z_stb = 1'b0;
    div_z = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        ph = 0;
        cnt = 0;
        hc = 0;
      end else if (pend) begin
        hc = 0;
        if (ph < 4) begin
          mw[ph] = cw;
          words.push_back(cw);
          ph++;
          if (ph == 4) begin
            mz = qmodel({mw[0], mw[1]}, {mw[2], mw[3]});
            cnt = 3;
          end
        end else ph = (ph == 5) ? 6 : 0;
      end
      if (ph == 4) begin
        if (cnt > 0) cnt--;
        else ph = 5;
      end
      div_a_ack = rst && ph < 2 && div_a_stb && hc >= hold;
      div_b_ack = rst && (ph == 2 || ph == 3) && div_b_stb && hc >= hold;
      if (rst && ph < 4 && (div_a_stb || div_b_stb)) hc++;
      div_z_stb = rst && (ph == 5 || ph == 6 || (stray && ph < 4));
      div_z = ph == 5 ? mz[31:16] : ph == 6 ? mz[15:0] : 16'hDEAD;
      cw = div_a_stb ? div_a : div_b;
      pend = (div_a_ack && div_a_stb) || (div_b_ack && div_b_stb) || (div_z_stb && div_z_ack && ph >= 5);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b, output bit ok);
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_valid[r] = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (req_ready[r]) ok = 1;
      else @(negedge clk);
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask
  task automatic await_rsp(input int r, output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rsp_valid[r]) ok = 1;
      else @(negedge clk);
    end
  endtask
  task automatic release_rsp(input int r);
    rsp_ready[r] = 1'b1;
    cyc(1);
    rsp_ready = '0;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    req_valid = '0;
    cyc(3);
    checks++;
    if ({busy, div_a_stb, div_b_stb, div_z_ack} !== 4'b0 || req_ready !== '0 || rsp_valid !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b stb_a=%b stb_b=%b zack=%b ready=%b valid=%b, want all 0", busy, div_a_stb, div_b_stb, div_z_ack, req_ready, rsp_valid);
    end
    checks++;
    if (div_a !== 16'h0 || div_b !== 16'h0 || rsp_z !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: div_a=%h div_b=%h rsp_z=%h, want 0", div_a, div_b, rsp_z);
    end
    checks++;
    if (grant_id !== 2'd0 || done_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: grant_id=%0d done_count=%h, want 0", grant_id, done_count);
    end
    rst = 1'b1;
    cyc(1);
  endtask
  task automatic test_single;
    bit ok;
    words.delete();
    req_a[95:64] = 32'h40C00000;
    req_b[95:64] = 32'h40000000;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: req_ready=%b, want 0100", req_ready);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd2 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL single_grant: busy=%b grant_id=%0d req_ready=%b, want 1 2 0000", busy, grant_id, req_ready);
    end
    req_valid = '0;
    await_rsp(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: no rsp_valid[2], want response");
    end
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_z !== 32'h40400000) begin
      errors++;
      $display("FAIL single_rsp: rsp_valid=%b rsp_z=%h, want 0100 40400000", rsp_valid, rsp_z);
    end
    release_rsp(2);
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0 || done_count !== 16'd1) begin
      errors++;
      $display("FAIL single_done: rsp_valid=%b busy=%b done_count=%0d, want 0000 0 1", rsp_valid, busy, done_count);
    end
    checks++;
    if (words.size() !== 4) begin
      errors++;
      $display("FAIL single_word_count: words=%0d, want 4", words.size());
    end else begin
      checks++;
      if ({words[0], words[1], words[2], words[3]} !== 64'h40C0_0000_4000_0000) begin
        errors++;
        $display("FAIL single_words: got %h %h %h %h, want 40c0 0000 4000 0000", words[0], words[1], words[2], words[3]);
      end
    end
  endtask
  task automatic test_specials;
    bit ok, ok2;
    issue(1, 32'h3F800000, 32'h00000000, ok);
    await_rsp(1, ok2);
    checks++;
    if (!ok || !ok2 || rsp_valid !== 4'b0010 || rsp_z !== 32'h7F800000) begin
      errors++;
      $display("FAIL special_inf: ok=%b/%b rsp_valid=%b rsp_z=%h, want 0010 7f800000", ok, ok2, rsp_valid, rsp_z);
    end
    release_rsp(1);
    issue(3, 32'h0, 32'h0, ok);
    await_rsp(3, ok2);
    checks++;
    if (!ok || !ok2 || grant_id !== 2'd3 || rsp_z !== 32'hFFC00000) begin
      errors++;
      $display("FAIL special_nan: ok=%b/%b grant_id=%0d rsp_z=%h, want 3 ffc00000", ok, ok2, grant_id, rsp_z);
    end
    release_rsp(3);
    checks++;
    if (done_count !== 16'd3) begin
      errors++;
      $display("FAIL special_count: done_count=%0d, want 3", done_count);
    end
  endtask
  task automatic test_fairness;
    logic [3:0] want;
    int w, bad;
    bit seen;
    rsp_ready = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h3F800000 + i;
      req_b[32*i +: 32] = 32'h40000000;
    end
    req_valid = 4'hF;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      want = 4'b0001 << (k % 4);
      w = 0;
      #1;
      while (req_ready === 4'b0 && w < 100) begin
        @(negedge clk);
        #1;
        w++;
      end
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("FAIL fair_grant%0d: req_ready=%b, want %b", k, req_ready, want);
      end
      if (k > 0) begin
        checks++;
        if (w != 0) begin
          errors++;
          $display("FAIL fair_b2b%0d: grant after %0d idle cycles, want 0", k, w);
        end
      end
      @(negedge clk);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        if (rsp_valid !== 4'b0) seen = 1;
        else begin
          if (req_ready !== 4'b0) bad++;
          @(negedge clk);
        end
      end
      checks++;
      if (rsp_valid !== want) begin
        errors++;
        $display("FAIL fair_rsp%0d: rsp_valid=%b, want %b", k, rsp_valid, want);
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = '0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fair_busy_ready: req_ready high while busy %0d times, want 0", bad);
    end
    checks++;
    if (done_count !== 16'd11) begin
      errors++;
      $display("FAIL fair_count: done_count=%0d, want 11", done_count);
    end
  endtask
  task automatic test_backpressure;
    bit ok, ok2;
    int bad, nw;
    issue(0, 32'h3F800000, 32'h00000000, ok);
    await_rsp(0, ok2);
    checks++;
    if (!ok || !ok2) begin
      errors++;
      $display("FAIL bp_reach: grant=%b rsp=%b, want 1 1", ok, ok2);
    end
    req_a[63:32] = 32'h41200000;
    req_b[63:32] = 32'h40A00000;
    req_valid[1] = 1'b1;
    nw = words.size();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_z !== 32'h7F800000 || rsp_valid !== 4'b0001 || div_a_stb !== 1'b0 || div_b_stb !== 1'b0 || div_z_ack !== 1'b0 || req_ready !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stall: %0d bad cycles, last rsp_z=%h rsp_valid=%b req_ready=%b, want 0", bad, rsp_z, rsp_valid, req_ready);
    end
    checks++;
    if (words.size() != nw) begin
      errors++;
      $display("FAIL bp_no_refeed: words=%0d, want %0d", words.size(), nw);
    end
    release_rsp(0);
    checks++;
    if (rsp_valid !== 4'b0 || req_ready !== 4'b0010 || done_count !== 16'd12) begin
      errors++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b done_count=%0d, want 0000 0010 12", rsp_valid, req_ready, done_count);
    end
    @(negedge clk);
    req_valid = '0;
    await_rsp(1, ok);
    checks++;
    if (!ok || rsp_z !== 32'h40000000) begin
      errors++;
      $display("FAIL bp_next: ok=%b rsp_z=%h, want 40000000", ok, rsp_z);
    end
    release_rsp(1);
  endtask
  task automatic test_hold;
    bit ok, ok2;
    int bad;
    hold = 2;
    words.delete();
    issue(2, 32'h40C00000, 32'h40000000, ok);
    bad = 0;
    repeat (3) begin
      if (div_a_stb !== 1'b1 || div_a !== 16'h40C0) bad++;
      @(negedge clk);
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL hold_stb: grant=%b bad=%0d div_a=%h, want held 40c0", ok, bad, div_a);
    end
    await_rsp(2, ok2);
    checks++;
    if (!ok2 || rsp_z !== 32'h40400000 || words.size() !== 4) begin
      errors++;
      $display("FAIL hold_rsp: ok=%b rsp_z=%h words=%0d, want 40400000 4", ok2, rsp_z, words.size());
    end
    hold = 0;
    release_rsp(2);
  endtask
  task automatic test_stray;
    bit ok, ok2;
    stray = 1'b1;
    cyc(3);
    checks++;
    if (div_z_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: div_z_ack=%b busy=%b, want 0 0", div_z_ack, busy);
    end
    issue(3, 32'h0, 32'h0, ok);
    await_rsp(3, ok2);
    checks++;
    if (!ok || !ok2 || rsp_z !== 32'hFFC00000) begin
      errors++;
      $display("FAIL stray_rsp: ok=%b/%b rsp_z=%h, want ffc00000", ok, ok2, rsp_z);
    end
    stray = 1'b0;
    release_rsp(3);
  endtask
  task automatic test_reset_mid;
    bit ok, seen;
    hold = 3;
    issue(2, 32'h12345678, 32'h9ABCDEF0, ok);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (div_b_stb === 1'b1 && div_b === 16'hDEF0) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!ok || !seen) begin
      errors++;
      $display("FAIL rstmid_reach: grant=%b send_b_lo=%b, want 1 1", ok, seen);
    end
    rst = 1'b0;
    cyc(1);
    checks++;
    if (busy !== 1'b0 || div_a_stb !== 1'b0 || div_b_stb !== 1'b0 || div_z_ack !== 1'b0 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_idle: busy=%b stb=%b%b zack=%b rsp_valid=%b, want all 0", busy, div_a_stb, div_b_stb, div_z_ack, rsp_valid);
    end
    checks++;
    if (done_count !== 16'd0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_regs: done_count=%0d grant_id=%0d, want 0 0", done_count, grant_id);
    end
    rst = 1'b1;
    hold = 0;
    cyc(1);
    issue(1, 32'h41200000, 32'h40A00000, ok);
    await_rsp(1, seen);
    checks++;
    if (!ok || !seen || grant_id !== 2'd1 || rsp_z !== 32'h40000000) begin
      errors++;
      $display("FAIL rstmid_next: ok=%b/%b grant_id=%0d rsp_z=%h, want 1 40000000", ok, seen, grant_id, rsp_z);
    end
    release_rsp(1);
    checks++;
    if (done_count !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_count: done_count=%0d, want 1", done_count);
    end
  endtask
  task automatic test_wrap;
    bit ok, ok2;
    force dut.done_count = 16'hFFFF;
    #1;
    release dut.done_count;
    cyc(1);
    checks++;
    if (done_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: done_count=%h, want ffff", done_count);
    end
    issue(0, 32'h00000001, 32'h00000002, ok);
    await_rsp(0, ok2);
    checks++;
    if (!ok || !ok2 || rsp_z !== 32'h00000003) begin
      errors++;
      $display("FAIL wrap_rsp: ok=%b/%b rsp_z=%h, want 00000003", ok, ok2, rsp_z);
    end
    release_rsp(0);
    checks++;
    if (done_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: done_count=%h, want 0000", done_count);
    end
  endtask
  initial begin
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    test_reset;
    test_single;
    test_specials;
    test_fairness;
    test_backpressure;
    test_hold;
    test_stray;
    test_reset_mid;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
